// File: rtl/aes_256_key_schedule_reverse.sv
// AES-256 reverse key schedule: walks RK14..RK0 from a two-key window (hi=RK_k, lo=RK_(k-1)),
// one round key per valid/ready handshake, with a registered SubWord stage before the XOR stage.

module aes_256_ksr_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_y
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign o_y = SBOX[i_a];
endmodule

module aes_256_key_schedule_reverse (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         load_key_13,
  input  logic         load_key_14,
  input  logic         start,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy,
  output logic         done
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [1:0] S_XOR  = 2'd3;

  logic [1:0]   r_state;
  logic [127:0] r_hi, r_lo;
  logic [3:0]   r_k;
  logic [31:0]  r_pl1;
  logic         r_done;

  logic [31:0]  w_sub_in, w_sub_out;
  logic [7:0]   w_rcon;
  logic [31:0]  w_a, w_b, w_c, w_d;

  // Even k uses RotWord + Rcon; odd k is the AES-256 mid-block SubWord-only step.
  assign w_sub_in = r_k[0] ? r_lo[31:0] : {r_lo[23:0], r_lo[31:24]};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_sbox
      aes_256_ksr_sbox u_sbox (
        .i_a (w_sub_in[8*g +: 8]),
        .o_y (w_sub_out[8*g +: 8])
      );
    end
  endgenerate

  always_comb begin
    w_rcon = 8'h00;
    if (!r_k[0]) begin
      case (r_k[3:1])
        3'd1:    w_rcon = 8'h01;
        3'd2:    w_rcon = 8'h02;
        3'd3:    w_rcon = 8'h04;
        3'd4:    w_rcon = 8'h08;
        3'd5:    w_rcon = 8'h10;
        3'd6:    w_rcon = 8'h20;
        3'd7:    w_rcon = 8'h40;
        default: w_rcon = 8'h00;
      endcase
    end
  end

  assign w_a = r_hi[127:96] ^ r_pl1 ^ {w_rcon, 24'h0};
  assign w_b = r_hi[95:64]  ^ r_hi[127:96];
  assign w_c = r_hi[63:32]  ^ r_hi[95:64];
  assign w_d = r_hi[31:0]   ^ r_hi[63:32];

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_k     <= '0;
      r_pl1   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load_key_13) r_lo <= key;
          if (load_key_14) r_hi <= key;
          if (start) begin
            r_k     <= 4'd14;
            r_state <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (rk_ready) begin
            if (r_k == 4'd0) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end else if (r_k == 4'd1) begin
              // RK0 is already in lo; no derivation step needed.
              r_hi <= r_lo;
              r_k  <= 4'd0;
            end else begin
              r_state <= S_SUB;
            end
          end
        end
        S_SUB: begin
          r_pl1   <= w_sub_out;
          r_state <= S_XOR;
        end
        S_XOR: begin
          r_hi    <= r_lo;
          r_lo    <= {w_a, w_b, w_c, w_d};
          r_k     <= r_k - 4'd1;
          r_state <= S_EMIT;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rk_out   = r_hi;
  assign rk_idx   = r_k;
  assign rk_valid = (r_state == S_EMIT);
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
endmodule

// File: tb/tb_aes_256_key_schedule_reverse.sv
// Directed bench for the reverse AES-256 key schedule against the FIPS-197 A.3 expansion.

module tb_aes_256_key_schedule_reverse;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key = '0;
  logic         load_key_13 = 1'b0, load_key_14 = 1'b0, start = 1'b0, rk_ready = 1'b0;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid, busy, done;

  aes_256_key_schedule_reverse dut (
    .clk(clk), .rst(rst), .key(key), .load_key_13(load_key_13), .load_key_14(load_key_14),
    .start(start), .rk_out(rk_out), .rk_idx(rk_idx), .rk_valid(rk_valid),
    .rk_ready(rk_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [127:0] exp_rk [15];

  task automatic expect_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Load RK13 this cycle, then RK14 together with start the next cycle.
  task automatic kick(input logic [127:0] k13, input logic [127:0] k14);
    key = k13; load_key_13 = 1'b1;
    @(negedge clk);
    load_key_13 = 1'b0; key = k14; load_key_14 = 1'b1; start = 1'b1;
  endtask

  // Collects keys until done; returns at the negedge where done is seen.
  task automatic run(input int duty, input bit poke, input int exp_cyc);
    int n = 14;
    int hs = 0;
    bit pv = 0, pr = 0, poked = 0;
    logic [127:0] po = '0;
    logic [3:0]   pi = '0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      if (cyc == 1 || poked) begin start = 1'b0; load_key_14 = 1'b0; load_key_13 = 1'b0; key = '0; end
      if (done) begin
        expect_eq("hs_count", 128'(hs), 128'd15);
        if (exp_cyc > 0) expect_eq("done_latency", 128'(cyc), 128'(exp_cyc));
        expect_eq("busy_at_done", {127'd0, busy}, 128'd0);
        return;
      end
      expect_eq("busy_in_run", {127'd0, busy}, 128'd1);
      if (pv && !pr) begin
        expect_eq("stall_out", rk_out, po);
        expect_eq("stall_idx", {124'd0, rk_idx}, {124'd0, pi});
      end
      if (poke && !poked && rk_valid && rk_idx == 4'd9) begin
        start = 1'b1; load_key_14 = 1'b1; key = '1; poked = 1'b1;
      end
      rk_ready = ($urandom_range(0, 99) < duty);
      if (rk_valid && rk_ready) begin
        expect_eq($sformatf("rk%0d", n), rk_out, (n >= 0) ? exp_rk[n] : '1);
        expect_eq($sformatf("idx%0d", n), {124'd0, rk_idx}, 128'(n));
        n--; hs++;
      end
      pv = rk_valid; pr = rk_ready; po = rk_out; pi = rk_idx;
    end
    expect_eq("done_timeout", {127'd0, done}, 128'd1);
  endtask

  initial begin
    bit seen;
    bit quiet;
    exp_rk[0]  = 128'h603deb1015ca71be2b73aef0857d7781;
    exp_rk[1]  = 128'h1f352c073b6108d72d9810a30914dff4;
    exp_rk[2]  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    exp_rk[3]  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    exp_rk[4]  = 128'hd59aecb85bf3c917fee94248de8ebe96;
    exp_rk[5]  = 128'hb5a9328a2678a647983122292f6c79b3;
    exp_rk[6]  = 128'h812c81addadf48ba24360af2fab8b464;
    exp_rk[7]  = 128'h98c5bfc9bebd198e268c3ba709e04214;
    exp_rk[8]  = 128'h68007bacb2df331696e939e46c518d80;
    exp_rk[9]  = 128'hc814e20476a9fb8a5025c02d59c58239;
    exp_rk[10] = 128'hde1369676ccc5a71fa2563959674ee15;
    exp_rk[11] = 128'h5886ca5d2e2f31d77e0af1fa27cf73c3;
    exp_rk[12] = 128'h749c47ab18501ddae2757e4f7401905a;
    exp_rk[13] = 128'hcafaaae3e4d59b349adf6acebd10190d;
    exp_rk[14] = 128'hfe4890d1e6188d0b046df344706c631e;

    repeat (2) @(negedge clk);
    expect_eq("rst_out", rk_out, '0);
    expect_eq("rst_flags", {123'd0, rk_idx, rk_valid}, '0);
    expect_eq("rst_busy_done", {126'd0, busy, done}, '0);
    rst = 1'b1;
    @(negedge clk);

    // Full run, ready tied high.
    kick(exp_rk[13], exp_rk[14]);
    run(100, 1'b0, 42);

    // Back-to-back, then backpressure and busy protection.
    kick(exp_rk[13], exp_rk[14]);
    run(100, 1'b0, 42);
    kick(exp_rk[13], exp_rk[14]);
    run(30, 1'b0, 0);
    kick(exp_rk[13], exp_rk[14]);
    run(50, 1'b1, 0);

    // Reset in the middle of a run.
    kick(exp_rk[13], exp_rk[14]);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      start = 1'b0; load_key_14 = 1'b0; key = '0;
      rk_ready = 1'b1;
      if (rk_valid && rk_idx == 4'd6) begin seen = 1'b1; rst = 1'b0; rk_ready = 1'b0; end
    end
    expect_eq("reach_idx6", {127'd0, seen}, 128'd1);
    @(negedge clk);
    expect_eq("midrst_out", rk_out, '0);
    expect_eq("midrst_flags", {121'd0, rk_idx, rk_valid, busy, done}, '0);
    rst = 1'b1;
    quiet = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) quiet = 1'b0;
    end
    expect_eq("midrst_quiet", {127'd0, quiet}, 128'd1);
    kick(exp_rk[13], exp_rk[14]);
    run(100, 1'b0, 42);

    // Zero window: RK12 = {SubWord(RotWord(0)) ^ Rcon, 0, 0, 0}.
    kick('0, '0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      start = 1'b0; load_key_14 = 1'b0; key = '0;
      rk_ready = 1'b1;
      if (rk_valid && rk_idx == 4'd12 && !seen) begin
        seen = 1'b1;
        expect_eq("zero_rk12", rk_out, 128'h23636363_00000000_00000000_00000000);
      end
    end
    expect_eq("zero_seen12", {127'd0, seen}, 128'd1);
    expect_eq("zero_done", {127'd0, done}, 128'd1);

    // Reload right after a done: no stale window data.
    kick(exp_rk[13], exp_rk[14]);
    run(100, 1'b0, 42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
